bit_serial_adder: RTL and testbench
===================================

// Module: bit_serial_adder
//
// PURPOSE
// - Multi-cycle LSB-first adder for the ALU low-area path; consumes one_bit_half_adder outputs.
// - Datapath per cycle: two one_bit_half_adder instances + OR gate form one full-adder bit
//   slice, fed by an internal carry flop.
// - Latches WIDTH-bit operands on start and processes one bit per clock.
// - Presents the registered sum and carry with a one-cycle done pulse to the ALU result mux.
//
// PARAMETERS
// - WIDTH   32   operand/result width in bits; legal range >= 2
//
// PORTS
// - clk_i      in   1      system clock, all flops rising-edge
// - rst_i      in   1      synchronous reset, active-high
// - start_i    in   1      request; sampled only when accepted (see BEHAVIOUR)
// - a_i        in   WIDTH  operand A, captured on accepted start
// - b_i        in   WIDTH  operand B, captured on accepted start
// - carry_i    in   1      carry-in, captured on accepted start
// - busy_o     out  1      high while bits are being processed
// - done_o     out  1      one-cycle pulse: sum_o/carry_o are valid and new
// - sum_o      out  WIDTH  registered result; held until next done_o
// - carry_o    out  1      registered carry-out of MSB; held with sum_o
//
// BEHAVIOUR
// - Reset: state=IDLE; busy_o=0, done_o=0, sum_o=0, carry_o=0; operand/shift regs and
//   bit counter cleared.
// - Reset takes effect on the next clock edge, including mid-operation:
//   - the operation is abandoned; no done_o follows.
//   - sum_o/carry_o go to 0.
// - FSM states:
//   - IDLE: start_i=1 -> SHIFT. Latch a_i, b_i into shift regs; carry flop <= carry_i;
//     counter <= 0.
//   - SHIFT: busy_o=1 each cycle.
//     - slice input = A[0], B[0], carry flop.
//     - slice sum shifts into result shift reg from MSB side; carry flop <= slice carry.
//     - A, B shift right by 1; counter++.
//     - When counter == WIDTH-1 this cycle -> DONE.
//   - DONE: done_o=1, busy_o=0; sum_o <= result shift reg; carry_o <= carry flop.
//     - Registers are updated on entry, so they are valid while done_o=1.
//     - start_i=1 -> SHIFT (back-to-back, same latch actions as IDLE); else -> IDLE.
// - Latency: start accepted at edge 0 -> busy_o high for WIDTH cycles -> done_o high in
//   cycle WIDTH+1.
// - Throughput with back-to-back starts: one result every WIDTH+1 cycles.
// - start_i during SHIFT: ignored; operands not re-latched; in-flight result unaffected.
// - Arithmetic:
//   - {carry_o, sum_o} = a + b + carry_in, modulo 2^(WIDTH+1).
//   - No signed interpretation; overflow detection is the consumer's job.
// - The counter is $clog2(WIDTH) bits wide and never wraps past WIDTH-1.
//
// CONFIGURATION
// - Macro: BIT_SERIAL_ADDER_SUB_EN
// - Defined:
//   - Adds port sub_i (in, 1), captured on accepted start.
//   - sub_i=1: latched B = ~b_i; carry flop <= 1 (carry_i ignored).
//     Result is a - b; carry_o=1 means no borrow.
//   - sub_i=0: identical to the undefined build.
// - Undefined: no sub_i port; addition only.
// - Timing and FSM are identical in both builds.
//
// TESTING (WIDTH=8 unless noted)
// - Reset:
//   - Hold rst_i 2 cycles -> busy_o=0, done_o=0, sum_o=8'h00, carry_o=0.
//   - Then start_i low for 10 cycles -> outputs unchanged.
// - Basic add: a=8'h3C, b=8'h05, carry_i=0, start pulse -> busy_o 8 cycles.
//   - done_o in cycle 9 with sum_o=8'h41, carry_o=0.
//   - sum_o still 8'h41 ten cycles later.
// - Carry chain: a=8'hFF, b=8'h01, carry_i=0 -> sum_o=8'h00, carry_o=1.
//   - a=8'hFF, b=8'hFF, carry_i=1 -> sum_o=8'hFF, carry_o=1.
// - Busy/back-to-back:
//   - Start 8'h10+8'h20, then start_i=1 with a=8'hAA in cycle 4 -> ignored.
//     Result 8'h30 at cycle 9.
//   - start_i=1 during the done_o cycle -> second result at cycle 18.
// - Mid-op reset: start 8'h12+8'h34; assert rst_i in cycle 4.
//   - Next cycle: busy_o=0, sum_o=0, carry_o=0; done_o never pulses.
// - BIT_SERIAL_ADDER_SUB_EN:
//   - sub_i=1, a=8'h05, b=8'h07 -> sum_o=8'hFE, carry_o=0.
//   - sub_i=1, a=8'h07, b=8'h05 -> sum_o=8'h02, carry_o=1.

Source files
------------

// File: rtl/bit_serial_adder.sv
// LSB-first multi-cycle adder: one full-adder slice built from two half adders and an OR gate,
// plus a carry flop, processes one operand bit per clock. Optional macro: BIT_SERIAL_ADDER_SUB_EN.

module one_bit_half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

module bit_serial_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
`ifdef BIT_SERIAL_ADDER_SUB_EN
  input  logic             sub_i,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-2:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic             cy_q;
  logic [CNT_W-1:0] cnt_q;

  logic             load_c;
  logic             shift_c;
  logic             last_c;
  logic             busy_d;
  logic             done_d;
  logic [WIDTH-1:0] b_lat_c;
  logic             cin_lat_c;

  logic ha0_sum;
  logic ha0_carry;
  logic slice_sum;
  logic ha1_carry;
  logic slice_carry;

  // Full-adder bit slice on the current LSBs and the running carry
  one_bit_half_adder u_ha0 (
    .a     (a_q[0]),
    .b     (b_q[0]),
    .sum   (ha0_sum),
    .carry (ha0_carry)
  );

  one_bit_half_adder u_ha1 (
    .a     (ha0_sum),
    .b     (cy_q),
    .sum   (slice_sum),
    .carry (ha1_carry)
  );

  assign slice_carry = ha0_carry | ha1_carry;
  assign last_c      = (cnt_q == CNT_LAST);
  // Result with this cycle's bit inserted; bit 0 only exists on the final cycle
  assign res_d       = {slice_sum, res_q};

  // Operand conditioning at capture time
  always_comb begin
    b_lat_c   = b_i;
    cin_lat_c = carry_i;
`ifdef BIT_SERIAL_ADDER_SUB_EN
    if (sub_i) begin
      b_lat_c   = ~b_i;
      cin_lat_c = 1'b1;
    end
`endif
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last_c) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = start_i ? ST_SHIFT : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output / control decode; busy/done are registered from the next state
  always_comb begin
    load_c  = 1'b0;
    shift_c = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    if (start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE))) begin
      load_c = 1'b1;
    end
    if (state_q == ST_SHIFT) begin
      shift_c = 1'b1;
    end
    if (state_d == ST_SHIFT) begin
      busy_d = 1'b1;
    end
    if (state_d == ST_DONE) begin
      done_d = 1'b1;
    end
  end

  // Datapath: operand capture, bit-serial shift, result publication
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      sum_o   <= '0;
      carry_o <= 1'b0;
    end else begin
      busy_o <= busy_d;
      done_o <= done_d;
      if (load_c) begin
        a_q   <= a_i;
        b_q   <= b_lat_c;
        cy_q  <= cin_lat_c;
        cnt_q <= '0;
      end else if (shift_c) begin
        a_q   <= {1'b0, a_q[WIDTH-1:1]};
        b_q   <= {1'b0, b_q[WIDTH-1:1]};
        res_q <= res_d[WIDTH-1:1];
        cy_q  <= slice_carry;
        if (last_c) begin
          sum_o   <= res_d;
          carry_o <= slice_carry;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder at WIDTH=8: vector table plus multi-cycle corner sequences.

module tb_bit_serial_adder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         cin = 1'b0;
`ifdef BIT_SERIAL_ADDER_SUB_EN
  logic         sub_in = 1'b0;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_vec  = 0;
  int n_fail = 0;

  logic [W:0] sb[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  vec_t vecs[9];

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .a_i     (a_in),
    .b_i     (b_in),
    .carry_i (cin),
`ifdef BIT_SERIAL_ADDER_SUB_EN
    .sub_i   (sub_in),
`endif
    .busy_o  (busy),
    .done_o  (done),
    .sum_o   (sum),
    .carry_o (cout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Caller is at a negedge; the start is accepted on the following posedge
  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                             input logic [W-1:0] es, input logic ec);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    cin   = c;
    sb.push_back({ec, es});
  endtask

  task automatic run_busy(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      check(name, {30'd0, busy, done}, 32'd2);
    end
  endtask

  task automatic expect_done(input string name);
    logic [W:0] e;
    check({name, "_done"}, {30'd0, busy, done}, 32'd1);
    if (sb.size() == 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s_sb: got empty scoreboard expected an entry", name);
    end else begin
      e = sb.pop_front();
      check({name, "_sum"}, 32'(sum), 32'(e[W-1:0]));
      check({name, "_cout"}, 32'(cout), 32'(e[W]));
    end
  endtask

  initial begin
    vecs[0] = '{8'h3C, 8'h05, 1'b0, 8'h41, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[7] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[8] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};

    // Reset held two cycles, then idle
    repeat (2) @(negedge clk);
    check("rst_state", {21'd0, busy, done, sum, cout}, 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_state", {21'd0, busy, done, sum, cout}, 32'd0);

    // Basic add, result held afterwards
    drive_start(8'h3C, 8'h05, 1'b0, 8'h41, 1'b0);
    run_busy("basic_busy", 8);
    @(negedge clk);
    expect_done("basic");
    repeat (10) @(negedge clk);
    check("basic_hold", {22'd0, done, sum, cout}, {22'd0, 1'b0, 8'h41, 1'b0});

    // Table-driven vectors
    foreach (vecs[i]) begin
      @(negedge clk);
      drive_start(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout);
      run_busy($sformatf("vec%0d_busy", i), 8);
      @(negedge clk);
      expect_done($sformatf("vec%0d", i));
    end

    // start during SHIFT is ignored
    @(negedge clk);
    drive_start(8'h10, 8'h20, 1'b0, 8'h30, 1'b0);
    run_busy("ign_busy", 3);
    @(negedge clk);
    check("ign_busy4", {30'd0, busy, done}, 32'd2);
    start = 1'b1;
    a_in  = 8'hAA;
    b_in  = 8'h55;
    run_busy("ign_busy", 4);
    @(negedge clk);
    expect_done("ignore");
    @(negedge clk);
    check("ign_after", {30'd0, busy, done}, 32'd0);

    // Back-to-back: new start in the done cycle
    drive_start(8'h01, 8'h02, 1'b1, 8'h04, 1'b0);
    run_busy("b2b_busy1", 8);
    @(negedge clk);
    expect_done("b2b_first");
    drive_start(8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0);
    run_busy("b2b_busy2", 8);
    @(negedge clk);
    expect_done("b2b_second");

    // Mid-operation reset abandons the operation
    @(negedge clk);
    start = 1'b1;
    a_in  = 8'h12;
    b_in  = 8'h34;
    cin   = 1'b0;
    run_busy("mid_busy", 3);
    @(negedge clk);
    check("mid_busy4", {30'd0, busy, done}, 32'd2);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst", {21'd0, busy, done, sum, cout}, 32'd0);
    rst = 1'b0;
    begin
      int seen_done = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (done) seen_done++;
      end
      check("mid_no_done", 32'(seen_done), 32'd0);
    end

`ifdef BIT_SERIAL_ADDER_SUB_EN
    // Subtraction: carry_i ignored, carry_o=1 means no borrow
    @(negedge clk);
    sub_in = 1'b1;
    drive_start(8'h05, 8'h07, 1'b0, 8'hFE, 1'b0);
    run_busy("sub0_busy", 8);
    @(negedge clk);
    expect_done("sub0");
    drive_start(8'h07, 8'h05, 1'b0, 8'h02, 1'b1);
    run_busy("sub1_busy", 8);
    @(negedge clk);
    expect_done("sub1");
    sub_in = 1'b0;
`endif

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
